// File: rtl/ones_pkg.sv
// Shared definitions for the ones-counter family: FSM state encodings,
// default vector width and a reusable population-count function.
package ones_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int W_MAX     = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Callers zero-extend narrower vectors; the result always fits in 4 bits.
    function automatic logic [3:0] popcount(input logic [W_MAX-1:0] x);
        logic [3:0] sum;
        sum = '0;
        for (int i = 0; i < W_MAX; i++) begin
            sum = sum + {3'b000, x[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/ones_popcount.sv
// Combinational population count of a WIDTH-bit vector into CNT_W bits.
import ones_pkg::*;

module ones_popcount #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] x,
    output logic [CNT_W-1:0] ones
);

    logic [W_MAX-1:0] x_ext;
    logic [3:0]       full;

    always_comb begin
        x_ext            = '0;
        x_ext[WIDTH-1:0] = x;
    end

    assign full = popcount(x_ext);
    assign ones = full[CNT_W-1:0];

endmodule

// File: rtl/ones_pattern_gen.sv
// Enumerates every WIDTH-bit vector with a requested number of ones over a
// valid/ready stream. Define ONES_GEN_DESC_EN to enumerate in descending order.
import ones_pkg::*;

module ones_pattern_gen #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] v,
    output logic             v_valid,
    input  logic             v_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Stream contract: v is presented with v_valid; a vector is consumed on a
    // rising edge where v_valid && v_ready, and v/v_valid stay stable until then.

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] STEP      = WIDTH'(1);
    localparam logic [CNT_W:0]   MAX_COUNT = (CNT_W + 1)'(WIDTH);

`ifdef ONES_GEN_DESC_EN
    localparam logic [WIDTH-1:0] CAND_INIT = ALL_ONES;
    localparam logic [WIDTH-1:0] CAND_LAST = '0;
`else
    localparam logic [WIDTH-1:0] CAND_INIT = '0;
    localparam logic [WIDTH-1:0] CAND_LAST = ALL_ONES;
`endif

    state_t           state;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] ones;

`ifdef ONES_GEN_DESC_EN
    assign cand_next = cand - STEP;
`else
    assign cand_next = cand + STEP;
`endif

    ones_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount (
        .x    (cand),
        .ones (ones)
    );

    // The terminal check precedes the step, so cand never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cand    <= '0;
            cnt_q   <= '0;
            v       <= '0;
            v_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if ({1'b0, count} > MAX_COUNT) begin
                            err <= 1'b1;
                        end else begin
                            cnt_q <= count;
                            cand  <= CAND_INIT;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (ones == cnt_q) begin
                        v       <= cand;
                        v_valid <= 1'b1;
                        state   <= ST_EMIT;
                    end else if (cand == CAND_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        cand <= cand_next;
                    end
                end
                ST_EMIT: begin
                    if (v_ready) begin
                        v_valid <= 1'b0;
                        if (cand == CAND_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            cand  <= cand_next;
                            state <= ST_SCAN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Self-checking bench for ones_pattern_gen (WIDTH=4): directed table of
// expected vector sets plus randomized jobs against a popcount reference.
module tb_ones_pattern_gen;

    localparam int W = 4;
    localparam int C = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [C-1:0] count;
    logic [W-1:0] v;
    logic         v_valid;
    logic         v_ready;
    logic         busy;
    logic         done;
    logic         err;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [C-1:0] cnt;
        logic [15:0]  mask;
        bit           exp_err;
        int           mode;
    } vec_t;

    vec_t tbl[7];

    ones_pattern_gen #(.WIDTH(W), .CNT_W(C)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .count   (count),
        .v       (v),
        .v_valid (v_valid),
        .v_ready (v_ready),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Expected queue in emission order from a set bitmask.
    task automatic fill_from_mask(input logic [15:0] mask);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
`ifdef ONES_GEN_DESC_EN
                exp_q.push_front(W'(i));
`else
                exp_q.push_back(W'(i));
`endif
            end
        end
    endtask

    // Reference: every W-bit value whose count of ones equals cnt.
    task automatic fill_model(input int cnt);
        logic [15:0] mask;
        logic [W-1:0] x;
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            x = W'(i);
            if ($countones(x) == cnt) mask[i] = 1'b1;
        end
        fill_from_mask(mask);
    endtask

    // mode 0: always ready; 1: ready low 4 cycles per vector; 2: random ready.
    task automatic run_job(input logic [C-1:0] cnt, input int mode);
        int first_idx, first_cyc, cyc, wait_n;
        bit pend, got_done;
        logic [W-1:0] pv;
`ifdef ONES_GEN_DESC_EN
        first_idx = 15 - int'(exp_q[0]);
`else
        first_idx = int'(exp_q[0]);
`endif
        first_cyc = -1;
        cyc = 1;
        wait_n = 0;
        pend = 1'b0;
        got_done = 1'b0;
        pv = '0;
        @(negedge clk);
        start = 1'b1;
        count = cnt;
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < 400) begin
            if (pend) begin
                chk("hold_valid", 32'(v_valid), 1);
                chk("hold_v", 32'(v), 32'(pv));
            end
            if (err) chk("no_err", 32'(err), 0);
            if (v_valid && first_cyc < 0) first_cyc = cyc;
            if (done) got_done = 1'b1;
            case (mode)
                0: v_ready = 1'b1;
                1: begin
                    if (v_valid && !pend) wait_n = 4;
                    v_ready = (wait_n == 0);
                    if (wait_n > 0) wait_n--;
                end
                default: v_ready = ($urandom_range(0, 2) != 0);
            endcase
            pend = v_valid && !v_ready;
            pv = v;
            if (v_valid && v_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_vec", 32'(v), 32'hFFFF);
                end else begin
                    chk("vec", 32'(v), 32'(exp_q.pop_front()));
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(got_done), 1);
        chk("remaining", 32'(exp_q.size()), 0);
        chk("latency", 32'(first_cyc), 32'(first_idx + 2));
        chk("busy_after", 32'(busy), 0);
        chk("done_pulse", 32'(done), 0);
        chk("valid_after", 32'(v_valid), 0);
    endtask

    task automatic run_err(input logic [C-1:0] cnt);
        @(negedge clk);
        start = 1'b1;
        count = cnt;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), 1);
        chk("err_busy", 32'(busy), 0);
        @(negedge clk);
        chk("err_clear", 32'(err), 0);
        for (int i = 0; i < 3; i++) begin
            chk("err_no_valid", 32'(v_valid), 0);
            chk("err_idle", 32'(busy), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        int accepted, bound;
        logic [C-1:0] rc;

        tbl[0] = '{cnt: 3'd2, mask: 16'h1668, exp_err: 1'b0, mode: 0};
        tbl[1] = '{cnt: 3'd0, mask: 16'h0001, exp_err: 1'b0, mode: 0};
        tbl[2] = '{cnt: 3'd4, mask: 16'h8000, exp_err: 1'b0, mode: 0};
        tbl[3] = '{cnt: 3'd1, mask: 16'h0116, exp_err: 1'b0, mode: 0};
        tbl[4] = '{cnt: 3'd5, mask: 16'h0000, exp_err: 1'b1, mode: 0};
        tbl[5] = '{cnt: 3'd3, mask: 16'h6880, exp_err: 1'b0, mode: 1};
        tbl[6] = '{cnt: 3'd2, mask: 16'h1668, exp_err: 1'b0, mode: 2};

        rst_n = 1'b0;
        start = 1'b0;
        count = '0;
        v_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_v", 32'(v), 0);
        chk("rst_valid", 32'(v_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        for (int t = 0; t < 7; t++) begin
            if (tbl[t].exp_err) begin
                run_err(tbl[t].cnt);
            end else begin
                fill_from_mask(tbl[t].mask);
                run_job(tbl[t].cnt, tbl[t].mode);
            end
        end

        // Reset while the third vector of count=2 is being presented.
        fill_from_mask(16'h1668);
        v_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        count = 3'd2;
        @(negedge clk);
        start = 1'b0;
        accepted = 0;
        bound = 0;
        while (bound < 100 && !(accepted == 2 && v_valid)) begin
            if (v_valid && v_ready) begin
                chk("rst_seq_vec", 32'(v), 32'(exp_q.pop_front()));
                accepted++;
            end
            @(negedge clk);
            bound++;
        end
        chk("rst_seq_reached", 32'(accepted == 2 && v_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(v_valid), 0);
        chk("abort_v", 32'(v), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle", 32'(busy), 0);
            @(negedge clk);
        end
        fill_from_mask(16'h0116);
        run_job(3'd1, 0);

        for (int r = 0; r < 12; r++) begin
            rc = C'($urandom_range(0, 7));
            if (rc > 3'd4) begin
                run_err(rc);
            end else begin
                fill_model(int'(rc));
                run_job(rc, 2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
